// File: rtl/adsr_pkg.sv
// Shared widths, unity-gain constant and envelope state encoding for the ADSR block.
package adsr_pkg;

  localparam int unsigned GAIN_W   = 16;
  localparam int unsigned GAIN_ONE = 32768;
  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [2:0] {
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE,
    DONE
  } adsr_state_t;

endpackage

// File: rtl/adsr_gain_mult.sv
// Combinational signed-sample by unsigned Q1.15 gain multiply, floor-shifted back to sample width.
module adsr_gain_mult
  import adsr_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic        [GAIN_W-1:0]   i_gain,
  output logic signed [SAMPLE_W-1:0] o_scaled
);

  localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] w_prod;

  // Gain is zero-extended so it stays non-negative inside the signed product.
  assign w_prod   = PROD_W'(i_sample) * PROD_W'($signed({1'b0, i_gain}));
  assign o_scaled = SAMPLE_W'(w_prod >>> (GAIN_W - 1));

endmodule

// File: rtl/adsr.sv
// ADSR envelope: a sample-driven FSM steps a saturating gain and scales each accepted sample.
module adsr
  import adsr_pkg::*;
#(
  parameter int unsigned ATTACK_STEP     = 1024,
  parameter int unsigned DECAY_STEP      = 512,
  parameter int unsigned SUSTAIN_LEVEL   = 16384,
  parameter int unsigned SUSTAIN_SAMPLES = 64,
  parameter int unsigned RELEASE_STEP    = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] pre_sample_in,
  input  logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] sample_out
);

  localparam int unsigned DECAY_FLOOR = SUSTAIN_LEVEL + DECAY_STEP;

  adsr_state_t                r_state;
  logic [GAIN_W-1:0]          r_gain;
  logic [31:0]                r_sus_cnt;

  logic [31:0]                w_gain_ext;
  logic [31:0]                w_attack_sum;
  logic [31:0]                w_attack_gain;
  logic [31:0]                w_decay_gain;
  logic [31:0]                w_release_gain;
  logic signed [SAMPLE_W-1:0] w_scaled;

  // Saturated next-gain candidates are formed in 32 bits so nothing can wrap.
  assign w_gain_ext     = 32'(r_gain);
  assign w_attack_sum   = w_gain_ext + ATTACK_STEP;
  assign w_attack_gain  = (w_attack_sum >= GAIN_ONE) ? GAIN_ONE : w_attack_sum;
  assign w_decay_gain   = (w_gain_ext > DECAY_FLOOR) ? (w_gain_ext - DECAY_STEP) : SUSTAIN_LEVEL;
  assign w_release_gain = (w_gain_ext > RELEASE_STEP) ? (w_gain_ext - RELEASE_STEP) : 32'd0;

  adsr_gain_mult u_mult (
    .i_sample (pre_sample_in),
    .i_gain   (r_gain),
    .o_scaled (w_scaled)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ATTACK;
      r_gain     <= '0;
      r_sus_cnt  <= '0;
      sample_out <= '0;
    end else if (in_ready) begin
      // Output always uses the gain held before this sample's update.
      sample_out <= (r_state == DONE) ? '0 : w_scaled;
      case (r_state)
        ATTACK: begin
          r_gain <= GAIN_W'(w_attack_gain);
          if (w_attack_gain == GAIN_ONE) r_state <= DECAY;
        end
        DECAY: begin
          r_gain <= GAIN_W'(w_decay_gain);
          if (w_decay_gain == SUSTAIN_LEVEL) begin
            r_state   <= SUSTAIN;
            r_sus_cnt <= '0;
          end
        end
        SUSTAIN: begin
          r_sus_cnt <= r_sus_cnt + 32'd1;
          if (r_sus_cnt + 32'd1 >= SUSTAIN_SAMPLES) r_state <= RELEASE;
        end
        RELEASE: begin
          r_gain <= GAIN_W'(w_release_gain);
          if (w_release_gain == 32'd0) r_state <= DONE;
        end
        DONE: begin
          r_gain <= '0;
        end
        default: begin
          r_state <= ATTACK;
          r_gain  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adsr.sv
// Self-checking bench for adsr: vector table, hand sequences and a randomized envelope run.
module tb_adsr;

  localparam int A_STEP = 1024;
  localparam int D_STEP = 512;
  localparam int SUS    = 16384;
  localparam int SUS_N  = 64;
  localparam int R_STEP = 256;
  localparam int ONE    = 32768;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] pre_sample_in = '0;
  logic               in_ready = 1'b0;
  logic signed [15:0] sample_out;

  int total = 0;
  int bad   = 0;
  int env_q[$];

  typedef struct {
    bit    rst_n;
    bit    rdy;
    int    x;
    int    exp;
    string name;
  } vec_t;

  vec_t vecs[11];

  adsr #(
    .ATTACK_STEP     (A_STEP),
    .DECAY_STEP      (D_STEP),
    .SUSTAIN_LEVEL   (SUS),
    .SUSTAIN_SAMPLES (SUS_N),
    .RELEASE_STEP    (R_STEP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pre_sample_in (pre_sample_in),
    .in_ready      (in_ready),
    .sample_out    (sample_out)
  );

  always #5 clk = ~clk;

  // Floor division of x*g by 2^15, done with plain integer arithmetic.
  function automatic int scale(input int x, input int g);
    longint p;
    longint q;
    p = longint'(x) * longint'(g);
    q = p / 32768;
    if (p < 0 && (p % 32768) != 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int model_gain(input int idx);
    return (idx < env_q.size()) ? env_q[idx] : 0;
  endfunction

  function automatic int rand16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  // Gain used by each accepted sample after reset, in order.
  task automatic build_envelope();
    int g;
    g = 0;
    do begin
      env_q.push_back(g);
      g = (g + A_STEP > ONE) ? ONE : g + A_STEP;
    end while (g != ONE);
    do begin
      env_q.push_back(g);
      g = (g - D_STEP < SUS) ? SUS : g - D_STEP;
    end while (g != SUS);
    for (int k = 0; k < ((SUS_N == 0) ? 1 : SUS_N); k++) env_q.push_back(SUS);
    do begin
      env_q.push_back(g);
      g = (g - R_STEP < 0) ? 0 : g - R_STEP;
    end while (g != 0);
  endtask

  task automatic apply(input bit rst_n, input bit rdy, input int x);
    reset         = rst_n;
    in_ready      = rdy;
    pre_sample_in = 16'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 0);
    apply(1'b0, 1'b1, 32767);
  endtask

  task automatic run_envelope(input bit fixed, input string tag);
    int idx;
    int last;
    int x;
    int exp;
    int cyc;
    bit rdy;
    idx  = 0;
    last = 0;
    cyc  = 0;
    do_reset();
    check({tag, "_reset"}, int'(sample_out), 0);
    while (idx < env_q.size() + 16) begin
      if (fixed) begin
        rdy = (cyc % 10 == 0);
        x   = 32767;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
        x   = rand16();
      end
      apply(1'b1, rdy, x);
      if (rdy) begin
        exp  = scale(x, model_gain(idx));
        check($sformatf("%s_s%0d_x%0d", tag, idx, x), int'(sample_out), exp);
        idx++;
        last = exp;
      end else if (!fixed) begin
        check($sformatf("%s_hold%0d", tag, cyc), int'(sample_out), last);
      end
      cyc++;
    end
  endtask

  initial begin
    build_envelope();

    vecs[0]  = '{1'b0, 1'b1, 32767,  0,     "rst_ignores_ready"};
    vecs[1]  = '{1'b0, 1'b0, 0,      0,     "rst_idle"};
    vecs[2]  = '{1'b1, 1'b1, -32768, 0,     "neg_full_gain0"};
    vecs[3]  = '{1'b1, 1'b1, -32768, -1024, "neg_full_gain1024"};
    vecs[4]  = '{1'b1, 1'b0, 1234,   -1024, "hold_a"};
    vecs[5]  = '{1'b1, 1'b0, -5,     -1024, "hold_b"};
    vecs[6]  = '{1'b1, 1'b1, 32767,  2047,  "pos_full_gain2048"};
    vecs[7]  = '{1'b1, 1'b1, 100,    9,     "small_pos_gain3072"};
    vecs[8]  = '{1'b1, 1'b1, -100,   -13,   "floor_neg_gain4096"};
    vecs[9]  = '{1'b1, 1'b1, -1,     -1,    "minus1_gain5120"};
    vecs[10] = '{1'b1, 1'b1, 1,      0,     "plus1_gain6144"};

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].rst_n, vecs[i].rdy, vecs[i].x);
      check(vecs[i].name, int'(sample_out), vecs[i].exp);
    end

    // Back-to-back ready cycles each count as a sample.
    do_reset();
    begin
      int exp_b2b[6];
      exp_b2b = '{0, 1023, 2047, 3071, 4095, 5119};
      for (int i = 0; i < 6; i++) begin
        apply(1'b1, 1'b1, 32767);
        check($sformatf("b2b_%0d", i), int'(sample_out), exp_b2b[i]);
      end
    end

    // Most negative sample at unity gain must not overflow.
    do_reset();
    for (int i = 0; i < 32; i++) apply(1'b1, 1'b1, 0);
    apply(1'b1, 1'b1, -32768);
    check("neg_full_unity", int'(sample_out), -32768);
    apply(1'b1, 1'b1, 32767);
    check("first_decay_step", int'(sample_out), scale(32767, 32256));

    // Reset in the middle of SUSTAIN restarts from ATTACK at gain 0.
    do_reset();
    for (int i = 0; i < 74; i++) apply(1'b1, 1'b1, 32767);
    check("in_sustain", int'(sample_out), 16383);
    apply(1'b0, 1'b1, 32767);
    check("mid_reset_out", int'(sample_out), 0);
    apply(1'b1, 1'b1, 32767);
    check("after_reset_s0", int'(sample_out), 0);
    apply(1'b1, 1'b1, 32767);
    check("after_reset_s1", int'(sample_out), 1023);

    run_envelope(1'b1, "fixed");
    run_envelope(1'b0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adsr.md
ADSR -- requirements
Module: adsr

Interface
REQ-001 Parameter ATTACK_STEP, default 1024, gain increment per accepted sample in ATTACK.
REQ-002 Parameter DECAY_STEP, default 512, gain decrement per accepted sample in DECAY.
REQ-003 Parameter SUSTAIN_LEVEL, default 16384, gain held in SUSTAIN (0..32768).
REQ-004 Parameter SUSTAIN_SAMPLES, default 64, accepted samples spent in SUSTAIN.
REQ-005 Parameter RELEASE_STEP, default 256, gain decrement per accepted sample in RELEASE.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 pre_sample_in  input  16  signed two's-complement raw audio sample.
REQ-009 in_ready  input  1  sample strobe; each clk cycle with in_ready=1 is one accepted sample.
REQ-010 sample_out  output  16  signed, registered, envelope-scaled sample.

Function
REQ-011 Internal gain SHALL be a 16-bit unsigned register, 0..32768, where 32768 = unity.
REQ-012 States SHALL be ATTACK, DECAY, SUSTAIN, RELEASE, DONE; all advance only on accepted samples.
REQ-013 On an accepted sample, sample_out SHALL load (pre_sample_in * gain) >>> 15 computed from the pre-update gain; 1-cycle latency.
REQ-014 Product SHALL be formed signed at ≥33 bits; arithmetic shift (floor toward -inf); low 16 bits kept; gain ≤ 32768 guarantees no overflow.
REQ-015 sample_out SHALL hold its value on cycles with in_ready=0.
REQ-016 ATTACK: gain <= min(gain+ATTACK_STEP, 32768); when new gain = 32768, next state DECAY.
REQ-017 DECAY: gain <= max(gain-DECAY_STEP, SUSTAIN_LEVEL); when new gain = SUSTAIN_LEVEL, next state SUSTAIN, sustain counter cleared.
REQ-018 SUSTAIN: gain held; counter increments per sample; on the SUSTAIN_SAMPLES-th sample next state RELEASE.
REQ-019 RELEASE: gain <= max(gain-RELEASE_STEP, 0); when new gain = 0, next state DONE.
REQ-020 DONE: gain stays 0, sample_out = 0 for every accepted sample until reset.
REQ-021 Saturation SHALL be computed without wrap (wider intermediate or compare-before-subtract).
REQ-022 If SUSTAIN_LEVEL = 32768 DECAY SHALL exit on its first sample; if SUSTAIN_SAMPLES = 0 SUSTAIN SHALL exit on its first sample.
REQ-023 in_ready held high N cycles SHALL count as N samples.

Reset
REQ-024 While reset=0 at a clk edge: state ATTACK, gain 0, sustain counter 0, sample_out 0; in_ready ignored.
REQ-025 Reset asserted mid-envelope SHALL restart from ATTACK at gain 0 on the next edge; no partial state retained.

Structure
REQ-026 Package adsr_pkg SHALL hold the state enum, GAIN_W=16, GAIN_ONE=32768, SAMPLE_W=16.
REQ-027 One sub-module adsr_gain_mult SHALL implement the signed×unsigned multiply-and-shift (combinational); envelope FSM lives in adsr.

Verification
REQ-028 Reset low 2 cycles, then sample 0x7FFF with in_ready every 10 cycles -> outputs 0, 1023, 2047, …; 33rd sample outputs 32767.
REQ-029 Continue -> gain falls 512/sample over 32 samples; SUSTAIN outputs 16383 for 64 samples; RELEASE steps 16384→0 over 64 samples; then 0.
REQ-030 pre_sample_in = -32768 at gain 1024 -> -1024; at gain 32768 -> -32768 (no overflow).
REQ-031 in_ready=0 with changing pre_sample_in -> sample_out unchanged.
REQ-032 Reset asserted during SUSTAIN -> next accepted sample outputs 0, following sample uses gain 1024.
REQ-033 in_ready high 5 consecutive cycles from reset -> gain 5120 after, sample_out tracks each cycle.
